enc_onehot2bin: RTL

ENC_ONEHOT2BIN -- requirements
Module: enc_onehot2bin

---
 rtl/enc_pkg.sv | 29 ++
 rtl/enc_oh_check.sv | 35 +++
 rtl/enc_onehot2bin.sv | 122 ++++++++++++
 3 files changed

// File: rtl/enc_pkg.sv
// -----------------------------------------------------------------------------
// enc_pkg -- shared definitions for the one-hot to binary encoder.
//   OH_W_DEF / BIN_W_DEF / CNT_W_DEF : default widths (one-hot in, binary out,
//                                      error counter)
//   ERR_CODE_ALL                     : all-ones code reported for an all-zero
//                                      word; users slice it to their BIN_W
//   lowest_set_idx()                 : index of the lowest set bit in a word of
//                                      up to 64 bits (0 for an all-zero word)
// -----------------------------------------------------------------------------
package enc_pkg;

  localparam int OH_W_DEF  = 15;
  localparam int BIN_W_DEF = 4;
  localparam int CNT_W_DEF = 8;

  // Wide enough for any practical BIN_W; consumers take the low BIN_W bits.
  localparam logic [31:0] ERR_CODE_ALL = '1;

  // Scanning from the top down leaves the lowest set index in idx.
  function automatic int unsigned lowest_set_idx(input logic [63:0] v);
    int unsigned idx;
    idx = 0;
    for (int i = 63; i >= 0; i--) begin
      if (v[i]) idx = unsigned'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/enc_oh_check.sv
// -----------------------------------------------------------------------------
// enc_oh_check -- combinational legality check and index finder for a one-hot
// code word.
//   oh_i  [OH_W-1:0]  : code word under test
//   idx_o [BIN_W-1:0] : index of the lowest set bit, or all ones when oh_i == 0
//   err_o             : 1 unless exactly one bit of oh_i is set
// OH_W must not exceed 64 (width of the package index helper).
// -----------------------------------------------------------------------------
module enc_oh_check
  import enc_pkg::*;
#(
  parameter int OH_W  = OH_W_DEF,
  parameter int BIN_W = BIN_W_DEF
) (
  input  logic [OH_W-1:0]  oh_i,
  output logic [BIN_W-1:0] idx_o,
  output logic             err_o
);

  logic is_zero;
  logic is_one_hot;

  always_comb begin
    is_zero    = (oh_i == '0);
    is_one_hot = ($countones(oh_i) == 1);
    err_o      = !is_one_hot;
    if (is_zero) begin
      idx_o = ERR_CODE_ALL[BIN_W-1:0];
    end else begin
      // Multi-hot words still report their lowest set bit.
      idx_o = BIN_W'(lowest_set_idx(64'(oh_i)));
    end
  end

endmodule

// File: rtl/enc_onehot2bin.sv
// -----------------------------------------------------------------------------
// enc_onehot2bin -- registered one-hot to binary encoder with a one-deep output
// register, valid/ready flow control and an optional saturating error counter.
//
// Ports:
//   clk        : clock, all state on the rising edge
//   rst        : asynchronous active-low reset
//   in_valid   : upstream word valid
//   in_ready   : block can accept a word this cycle
//   in         : one-hot code word [OH_W-1:0]
//   out_valid  : registered result valid
//   out_ready  : downstream accepts the result
//   out        : binary index [BIN_W-1:0] (all ones for an all-zero word)
//   err        : held result came from a zero or multi-hot word
//   err_clr    : synchronous clear of err_cnt (wins over an increment)
//   err_cnt    : saturating count of accepted illegal words [CNT_W-1:0]
//
// Build option: define ENC_ONEHOT2BIN_ERRCNT_EN to build the error counter.
// Without it err_cnt is tied to 0 and err_clr is ignored.
//
// Handshake: a transfer happens on a rising edge where valid & ready are both
// 1. in_ready = !out_valid | out_ready and never looks at in_valid, so a pop
// and a new accept can share one edge (one word per cycle). While out_valid=1
// and out_ready=0 the output register holds out/err/out_valid unchanged.
// -----------------------------------------------------------------------------
module enc_onehot2bin
  import enc_pkg::*;
#(
  parameter int OH_W  = OH_W_DEF,
  parameter int BIN_W = BIN_W_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [OH_W-1:0]  in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [BIN_W-1:0] out,
  output logic             err,
  input  logic             err_clr,
  output logic [CNT_W-1:0] err_cnt
);

  logic             accept;
  logic [BIN_W-1:0] chk_idx;
  logic             chk_err;

  logic             out_valid_q, out_valid_d;
  logic [BIN_W-1:0] out_q, out_d;
  logic             err_q, err_d;

  enc_oh_check #(
    .OH_W  (OH_W),
    .BIN_W (BIN_W)
  ) u_check (
    .oh_i  (in),
    .idx_o (chk_idx),
    .err_o (chk_err)
  );

  always_comb begin
    in_ready    = !out_valid_q || out_ready;
    accept      = in_valid && in_ready;
    out_valid_d = out_valid_q;
    out_d       = out_q;
    err_d       = err_q;
    if (accept) begin
      out_valid_d = 1'b1;
      out_d       = chk_idx;
      err_d       = chk_err;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  // Reset drops any word in flight; nothing is replayed after release.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_valid_q <= 1'b0;
      out_q       <= '0;
      err_q       <= 1'b0;
    end else begin
      out_valid_q <= out_valid_d;
      out_q       <= out_d;
      err_q       <= err_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out       = out_q;
  assign err       = err_q;

`ifdef ENC_ONEHOT2BIN_ERRCNT_EN
  logic [CNT_W-1:0] err_cnt_q, err_cnt_d;

  always_comb begin
    err_cnt_d = err_cnt_q;
    if (err_clr) begin
      err_cnt_d = '0;
    end else if (accept && chk_err && (err_cnt_q != '1)) begin
      err_cnt_d = err_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      err_cnt_q <= '0;
    end else begin
      err_cnt_q <= err_cnt_d;
    end
  end

  assign err_cnt = err_cnt_q;
`else
  logic unused_err_clr;
  assign unused_err_clr = err_clr;
  assign err_cnt        = '0;
`endif

endmodule
